udp_line_fifo: RTL and testbench

Store-and-forward packet buffer between the RGB-to-UDP framer and the UDP/IP transmit stack. It accepts the framer's byte stream, which has no backpressure, and commits each packet only when its `in_last` byte arrives. It then presents committed packets to the UDP stack with a valid/ready handshake and a per-packet byte length. Packets that do not fit are dropped whole, and any partial packet is discarded on flush, so the stack never sees a truncated datagram.

---
 rtl/top_pkg.sv | 14 +
 rtl/sdp_ram_1r1w.sv | 22 ++
 rtl/udp_line_fifo.sv | 189 ++++++++++++++++++
 tb/tb_udp_line_fifo.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/top_pkg.sv
// Shared types and buffer defaults for the RGB-to-UDP transmit path.
package top_pkg;

    typedef logic [7:0]  bus8_t;
    typedef logic [15:0] bus16_t;

    localparam int     FIFO_ADDR_W     = 11;
    localparam int     FIFO_PKT_W      = 3;
    localparam bus16_t MAX_UDP_PAYLOAD = 16'd1472;

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_LOAD, R_SEND} rd_state_t;

endpackage

// File: rtl/sdp_ram_1r1w.sv
// Simple dual-port byte RAM: one write port, one registered read port.
module sdp_ram_1r1w #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/udp_line_fifo.sv
// Store-and-forward packet buffer: commits whole packets from the framer and
// replays them to the UDP stack with a per-packet length.
module udp_line_fifo
    import top_pkg::*;
#(
    parameter int     ADDR_W  = FIFO_ADDR_W,
    parameter int     PKT_W   = FIFO_PKT_W,
    parameter bus16_t MAX_LEN = MAX_UDP_PAYLOAD
) (
    input  logic        clk,
    input  logic        rst,
    input  bus8_t       in_data,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic        in_flush,
    output bus8_t       out_data,
    output logic        out_valid,
    output logic        out_last,
    output bus16_t      out_length,
    input  logic        out_ready,
    output logic        pkt_avail,
    output logic [15:0] drop_cnt
);

    localparam logic [ADDR_W:0] RAM_DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [PKT_W:0]  LF_DEPTH  = {1'b1, {PKT_W{1'b0}}};
    localparam logic [PKT_W:0]  LF_ONE    = {{PKT_W{1'b0}}, 1'b1};

    wr_state_t w_state, w_next;
    rd_state_t r_state, r_next;

    logic [ADDR_W:0] wr_ptr, wr_ptr_next, commit_ptr, rd_ptr, fetch_ptr;
    bus16_t          len, len_inc, len_next, remain, fetch_left;
    logic            ram_we, ram_full, commit, drop;

    bus16_t          lf_mem [2**PKT_W];
    logic [PKT_W:0]  lf_wp, lf_rp;
    logic            lf_full, lf_empty, load, pop;

    logic            issue, move, xfer, q_valid;
    bus8_t           ram_q;

    // Full test uses the registered rd_ptr, so freed space appears a cycle late.
    assign ram_full = (wr_ptr - rd_ptr) == RAM_DEPTH;
    assign lf_full  = (lf_wp - lf_rp) == LF_DEPTH;
    assign lf_empty = (lf_wp == lf_rp);

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next      = w_state;
        wr_ptr_next = wr_ptr;
        len_next    = len;
        len_inc     = (w_state == W_FILL) ? len + 16'd1 : 16'd1;
        ram_we      = 1'b0;
        commit      = 1'b0;
        drop        = 1'b0;
        if (in_flush) begin
            wr_ptr_next = commit_ptr;
            w_next      = W_IDLE;
        end else if (in_valid) begin
            case (w_state)
                W_IDLE, W_FILL: begin
                    if (ram_full || len_inc > MAX_LEN) begin
                        drop        = 1'b1;
                        wr_ptr_next = commit_ptr;
                        w_next      = in_last ? W_IDLE : W_DROP;
                    end else if (in_last && lf_full) begin
                        drop        = 1'b1;
                        wr_ptr_next = commit_ptr;
                        w_next      = W_IDLE;
                    end else begin
                        ram_we      = 1'b1;
                        wr_ptr_next = wr_ptr + PTR_ONE;
                        len_next    = len_inc;
                        commit      = in_last;
                        w_next      = in_last ? W_IDLE : W_FILL;
                    end
                end
                W_DROP:  if (in_last) w_next = W_IDLE;
                default: w_next = W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            len        <= '0;
            lf_wp      <= '0;
            drop_cnt   <= '0;
        end else begin
            wr_ptr <= wr_ptr_next;
            len    <= len_next;
            if (commit) begin
                commit_ptr                 <= wr_ptr_next;
                lf_mem[lf_wp[PKT_W-1:0]]   <= len_inc;
                lf_wp                      <= lf_wp + LF_ONE;
            end
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // Two-deep read pipeline: RAM output stage feeding the output register.
    assign xfer     = out_valid & out_ready;
    assign move     = q_valid & (~out_valid | xfer);
    assign issue    = (r_state != R_IDLE) && (fetch_left != 16'd0) && (~q_valid || move);
    assign out_last = out_valid && (remain == 16'd1);

    always_comb begin
        r_next = r_state;
        load   = 1'b0;
        pop    = 1'b0;
        case (r_state)
            R_IDLE: if (!lf_empty) begin
                r_next = R_LOAD;
                load   = 1'b1;
            end
            R_LOAD: r_next = R_SEND;
            R_SEND: if (xfer && out_last) begin
                r_next = R_IDLE;
                pop    = 1'b1;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            fetch_ptr  <= '0;
            remain     <= '0;
            fetch_left <= '0;
            out_length <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            q_valid    <= 1'b0;
            lf_rp      <= '0;
            pkt_avail  <= 1'b0;
        end else begin
            if (load) begin
                out_length <= lf_mem[lf_rp[PKT_W-1:0]];
                remain     <= lf_mem[lf_rp[PKT_W-1:0]];
                fetch_left <= lf_mem[lf_rp[PKT_W-1:0]];
                fetch_ptr  <= rd_ptr;
            end else begin
                if (issue) begin
                    fetch_ptr  <= fetch_ptr + PTR_ONE;
                    fetch_left <= fetch_left - 16'd1;
                end
                if (xfer) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                    remain <= remain - 16'd1;
                end
            end
            if (issue)     q_valid <= 1'b1;
            else if (move) q_valid <= 1'b0;
            if (move) begin
                out_data  <= ram_q;
                out_valid <= 1'b1;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
            if (pop) lf_rp <= lf_rp + LF_ONE;
            pkt_avail <= !lf_empty;
        end
    end

    sdp_ram_1r1w #(.ADDR_W(ADDR_W), .DATA_W(8)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (in_data),
        .re    (issue),
        .raddr (fetch_ptr[ADDR_W-1:0]),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_udp_line_fifo.sv
// Self-checking bench for udp_line_fifo: table of single packets followed by
// hand-written overflow, flush, backpressure, length-FIFO-full and reset cases.
module tb_udp_line_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid, in_last, in_flush;
    logic [7:0]  out_data;
    logic        out_valid, out_last, out_ready, pkt_avail;
    logic [15:0] out_length, drop_cnt;

    int tests = 0;
    int fails = 0;
    int exp_drops = 0;

    always #5 clk = ~clk;

    udp_line_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_flush   (in_flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_length (out_length),
        .out_ready  (out_ready),
        .pkt_avail  (pkt_avail),
        .drop_cnt   (drop_cnt)
    );

    typedef struct {
        int len;
        int seed;
        int exp_len;
        int exp_lat;
        int drop_inc;
    } vec_t;

    vec_t vecs [6];

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drives one packet, byte i = seed+i; returns on the negedge after the last byte's edge.
    task automatic applyStimulus(input int len, input int seed);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'(seed + i);
            in_last  = (i == len - 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic waitValid(output int lat, output int pa_lat);
        lat    = 0;
        pa_lat = pkt_avail ? 0 : -1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (pa_lat < 0 && pkt_avail) pa_lat = lat;
        end
    endtask

    task automatic drainPacket(input string tag, input int exp_len, input int seed, input bit random_ready);
        int cnt = 0, cyc = 0, first = -1, last_c = -1;
        int bad_data = 0, bad_last = 0, bad_len = 0, bad_hold = 0;
        bit stalled = 1'b0;
        logic [7:0]  hd = '0;
        logic        hl = 1'b0;
        logic [15:0] hlen = '0;
        while (cnt < exp_len && cyc < exp_len * 4 + 50) begin
            @(negedge clk);
            cyc++;
            out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled && (!out_valid || out_data != hd || out_last != hl || out_length != hlen))
                bad_hold++;
            stalled = 1'b0;
            if (out_valid) begin
                if (out_length != 16'(exp_len)) bad_len++;
                if (out_ready) begin
                    if (out_data != 8'(seed + cnt)) bad_data++;
                    if (out_last != (cnt == exp_len - 1)) bad_last++;
                    if (first < 0) first = cyc;
                    last_c = cyc;
                    cnt++;
                end else begin
                    stalled = 1'b1;
                    hd      = out_data;
                    hl      = out_last;
                    hlen    = out_length;
                end
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, " byte count"}, cnt, exp_len);
        checkOutput({tag, " data errors"}, bad_data, 0);
        checkOutput({tag, " last errors"}, bad_last, 0);
        checkOutput({tag, " length errors"}, bad_len, 0);
        if (random_ready) checkOutput({tag, " hold errors"}, bad_hold, 0);
        else              checkOutput({tag, " burst span"}, last_c - first, exp_len - 1);
    endtask

    task automatic expectIdle(input string tag, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkOutput({tag, " unexpected out_valid"}, seen, 0);
        checkOutput({tag, " pkt_avail idle"}, int'(pkt_avail), 0);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat, pa_lat, cnt, guard;

        vecs[0] = '{640,  'h00, 640,  3, 0};
        vecs[1] = '{1,    'h5A, 1,    3, 0};
        vecs[2] = '{2,    'hF0, 2,    3, 0};
        vecs[3] = '{1472, 'h11, 1472, 3, 0};
        vecs[4] = '{1473, 'h22, 0,    0, 1};
        vecs[5] = '{3,    'h07, 3,    3, 0};

        rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
        in_flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset out_valid", int'(out_valid), 0);
        checkOutput("reset out_last", int'(out_last), 0);
        checkOutput("reset pkt_avail", int'(pkt_avail), 0);
        checkOutput("reset out_length", int'(out_length), 0);
        checkOutput("reset out_data", int'(out_data), 0);
        checkOutput("reset drop_cnt", int'(drop_cnt), 0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].len, vecs[v].seed);
            exp_drops += vecs[v].drop_inc;
            if (vecs[v].exp_len > 0) begin
                waitValid(lat, pa_lat);
                checkOutput($sformatf("vec%0d out_valid latency", v), lat, vecs[v].exp_lat);
                checkOutput($sformatf("vec%0d pkt_avail latency", v), pa_lat, 1);
                drainPacket($sformatf("vec%0d", v), vecs[v].exp_len, vecs[v].seed, 1'b0);
            end else begin
                expectIdle($sformatf("vec%0d", v), 8);
            end
            checkOutput($sformatf("vec%0d drop_cnt", v), int'(drop_cnt), exp_drops);
        end

        // Three 640-byte lines fill 1920 bytes; the fourth runs out of room.
        for (int k = 0; k < 4; k++) applyStimulus(640, k * 16);
        exp_drops++;
        checkOutput("overflow drop_cnt", int'(drop_cnt), exp_drops);
        for (int k = 0; k < 3; k++) drainPacket($sformatf("overflow pkt%0d", k), 640, k * 16, 1'b0);
        expectIdle("overflow tail", 6);

        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'(i);
        end
        @(negedge clk);
        in_flush = 1'b1; in_data = 8'hEE; in_last = 1'b0;
        @(negedge clk);
        in_flush = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        expectIdle("flush partial", 6);
        applyStimulus(10, 'h20);
        drainPacket("flush pkt", 10, 'h20, 1'b0);
        checkOutput("flush drop_cnt", int'(drop_cnt), exp_drops);
        expectIdle("flush tail", 6);

        applyStimulus(64, 'h80);
        drainPacket("backpressure", 64, 'h80, 1'b1);

        for (int k = 0; k < 9; k++) applyStimulus(4, 'h40 + k * 8);
        exp_drops++;
        checkOutput("lenfifo drop_cnt", int'(drop_cnt), exp_drops);
        for (int k = 0; k < 8; k++) drainPacket($sformatf("lenfifo pkt%0d", k), 4, 'h40 + k * 8, 1'b0);
        expectIdle("lenfifo tail", 6);

        applyStimulus(640, 'h33);
        cnt = 0; guard = 0;
        while (cnt < 299 && guard < 2000) begin
            @(negedge clk);
            out_ready = 1'b1;
            guard++;
            if (out_valid) cnt++;
        end
        @(negedge clk);
        checkOutput("midread byte 300", int'(out_data), (8'h33 + 299) % 256);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midread reset out_valid", int'(out_valid), 0);
        checkOutput("midread reset out_last", int'(out_last), 0);
        checkOutput("midread reset pkt_avail", int'(pkt_avail), 0);
        checkOutput("midread reset out_length", int'(out_length), 0);
        checkOutput("midread reset out_data", int'(out_data), 0);
        checkOutput("midread reset drop_cnt", int'(drop_cnt), 0);
        rst = 1'b0;
        out_ready = 1'b0;
        exp_drops = 0;
        applyStimulus(20, 'h44);
        drainPacket("post-reset pkt", 20, 'h44, 1'b0);
        expectIdle("post-reset tail", 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
